max_reduce_ctrl: RTL



---
 rtl/max_reduce_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/max_reduce_ctrl.sv
// Frame-based max reduction controller: streams len words through one shared
// unsigned greater-than/select datapath and reports the maximum and its first index.

module max_reduce_dp #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         gt,
  output logic [W-1:0] mx
);
  // Strict compare: equal operands select b, so ties keep the accumulator.
  assign gt = (a > b);
  assign mx = gt ? a : b;
endmodule

module max_reduce_ctrl #(
  parameter int W  = 32,
  parameter int LW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [LW-1:0] frame_len,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_max,
  output logic [LW-1:0] out_idx,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

  state_t        r_state;
  logic [LW-1:0] r_len;
  logic [LW-1:0] r_count;
  logic [W-1:0]  r_acc;
  logic [LW-1:0] r_idx;
  logic [W-1:0]  r_out_max;
  logic [LW-1:0] r_out_idx;

  logic          w_gt;
  logic [W-1:0]  w_max;
  logic          w_first;
  logic          w_last;
  logic          w_beat;
  logic [W-1:0]  w_nxt_acc;
  logic [LW-1:0] w_nxt_idx;

  max_reduce_dp #(.W(W)) u_dp (
    .a  (in_data),
    .b  (r_acc),
    .gt (w_gt),
    .mx (w_max)
  );

  assign w_first   = (r_count == '0);
  assign w_last    = (r_count == r_len - LW'(1));
  assign w_beat    = in_valid && in_ready;
  assign w_nxt_acc = w_first ? in_data : w_max;
  assign w_nxt_idx = w_first ? '0 : (w_gt ? r_count : r_idx);

  assign in_ready  = (r_state == ACCUM);
  assign out_valid = (r_state == OUT);
  assign busy      = (r_state != IDLE);
  assign out_max   = r_out_max;
  assign out_idx   = r_out_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_len     <= '0;
      r_count   <= '0;
      r_acc     <= '0;
      r_idx     <= '0;
      r_out_max <= '0;
      r_out_idx <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            if (frame_len != '0) begin
              r_len   <= frame_len;
              r_count <= '0;
              r_state <= ACCUM;
            end else begin
              r_out_max <= '0;
              r_out_idx <= '0;
              r_state   <= OUT;
            end
          end
        end
        ACCUM: begin
          if (w_beat) begin
            r_count <= r_count + LW'(1);
            r_acc   <= w_nxt_acc;
            r_idx   <= w_nxt_idx;
            // Result is taken from the next-state values so the final beat counts.
            if (w_last) begin
              r_out_max <= w_nxt_acc;
              r_out_idx <= w_nxt_idx;
              r_state   <= OUT;
            end
          end
        end
        OUT: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
